// File: rtl/beta_mem_pkg.sv
// Shared types and constants for the data memory responder: FSM state encoding,
// latency counter width and the data word returned on a rejected access.
package beta_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RDY,
    WR_WAIT,
    WR_DONE
  } state_e;

  localparam int          LAT_W    = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/data_mem_resp_mem_array.sv
// DEPTH x 32 storage: synchronous write, registered read, contents never reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Latency-configurable data memory responder with read/write level handshakes.
// Optional alignment/range checking with memErr output under MEM_ALIGN_CHECK_EN.
module data_mem_resp
  import beta_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        MemRead,
  input  logic        MemReadDone,
  input  logic        MemWriteReady,
  output logic [31:0] memReadData,
  output logic        MemReadReady,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        memErr,
`endif
  output logic        MemWriteDone
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic               rrdy_q, wdone_q, merr_q;
  logic [31:0]        rdata_q;
  logic               mem_we;
  logic [31:0]        mem_rdata;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_err;
  logic               unused_addr_bits;

  assign acc_idx          = memAddr[IDX_W+1:2];
  assign unused_addr_bits = ^{memAddr[31:IDX_W+2], memAddr[1:0], merr_q};

`ifdef MEM_ALIGN_CHECK_EN
  assign acc_err = (memAddr[1:0] != 2'b00) || (memAddr[31:2] >= 30'(DEPTH));
  assign memErr  = merr_q;
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWriteReady) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_LOAD;
          idx_d   = acc_idx;
          wdata_d = memWriteData;
          err_d   = acc_err;
        end else if (MemRead) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
          idx_d   = acc_idx;
          err_d   = acc_err;
        end
      end
      RD_WAIT: begin
        if (!MemRead) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RD_RDY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_RDY: begin
        if (MemReadDone) state_d = IDLE;
      end
      WR_WAIT: begin
        if (!MemWriteReady) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // The only cycle that commits a write: leaving WR_WAIT for WR_DONE.
          state_d = WR_DONE;
          mem_we  = !err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_DONE: begin
        if (!MemWriteReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rrdy_q  <= 1'b0;
      wdone_q <= 1'b0;
      merr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rrdy_q  <= (state_d == RD_RDY);
      wdone_q <= (state_d == WR_DONE);
      merr_q  <= ((state_d == RD_RDY) || (state_d == WR_DONE)) && err_d;
      rdata_q <= (state_d == RD_RDY) ? (err_d ? ERR_DATA : mem_rdata) : '0;
    end
  end

  // Latched request payload needs no reset; it is only consumed after acceptance.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_d),
    .rdata_o (mem_rdata)
  );

  assign memReadData  = rdata_q;
  assign MemReadReady = rrdy_q;
  assign MemWriteDone = wdone_q;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, range 1..15, meaning cycles from request acceptance to completion.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port memAddr, input, 32 bits: byte address; word index is memAddr[log2(DEPTH)+1:2].
REQ-006 SHALL have port memWriteData, input, 32 bits: store data.
REQ-007 SHALL have port MemRead, input, 1 bit: read request level.
REQ-008 SHALL have port MemReadDone, input, 1 bit: initiator has consumed read data.
REQ-009 SHALL have port MemWriteReady, input, 1 bit: write request level.
REQ-010 SHALL have port memReadData, output, 32 bits: read data.
REQ-011 SHALL have port MemReadReady, output, 1 bit: memReadData valid.
REQ-012 SHALL have port MemWriteDone, output, 1 bit: write committed.

Function
REQ-013 SHALL implement FSM states IDLE, RD_WAIT, RD_RDY, WR_WAIT, WR_DONE.
REQ-014 IDLE: MemWriteReady=1 -> WR_WAIT; else MemRead=1 -> RD_WAIT. Write wins when both are high.
REQ-015 SHALL latch the word index (and write data on a write) at acceptance and ignore later memAddr/memWriteData changes.
REQ-016 RD_WAIT/WR_WAIT SHALL count LATENCY-1 cycles on a 4-bit down-counter, then move to RD_RDY/WR_DONE.
REQ-017 RD_RDY SHALL drive memReadData=mem[latched index] and MemReadReady=1, both registered, held stable until MemReadDone=1.
REQ-018 On MemReadDone=1 in RD_RDY, SHALL deassert MemReadReady next cycle and return to IDLE.
REQ-019 Entry to WR_DONE SHALL write mem[latched index] exactly once and assert MemWriteDone=1.
REQ-020 WR_DONE SHALL hold MemWriteDone=1 until MemWriteReady=0, then deassert next cycle and return to IDLE.
REQ-021 Request withdrawn (MemRead=0 in RD_WAIT, MemWriteReady=0 in WR_WAIT) SHALL abort to IDLE, with no write and no ready/done pulse.
REQ-022 memReadData SHALL be 0 in every state except RD_RDY.
REQ-023 Word index SHALL wrap modulo DEPTH; upper address bits are ignored.
REQ-024 Minimum read turnaround SHALL be LATENCY+1 cycles from MemRead rise to MemReadReady.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, counter=0, MemReadReady=0, MemWriteDone=0, memReadData=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no write; array contents are not cleared.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: SHALL add output memErr (1 bit); a request with memAddr[1:0]!=0 or memAddr word index >= DEPTH completes normally in handshake terms but suppresses the write, returns 32'hDEADBEEF, and asserts memErr alongside MemReadReady/MemWriteDone.
REQ-028 Macro undefined: no memErr port, no checks, low address bits ignored.

Structure
REQ-029 Package beta_mem_pkg SHALL hold the FSM state enum, the LATENCY width constant, and the error-data constant 32'hDEADBEEF.
REQ-030 Storage SHALL be sub-module mem_array: synchronous write, registered read, DEPTH x 32, no reset.

Verification
REQ-031 Write 0x12345678 to 0x40, then read 0x40 -> MemWriteDone after LATENCY+1 cycles; MemReadReady with memReadData=0x12345678.
REQ-032 MemRead and MemWriteReady rise together at 0x10 -> write serviced first; read after return to IDLE returns the new data.
REQ-033 Hold MemReadDone=0 for 5 cycles in RD_RDY -> MemReadReady and memReadData stable all 5 cycles.
REQ-034 Assert reset during WR_WAIT at 0x20 (old data 0xAAAA0000) -> outputs 0 immediately; later read of 0x20 returns 0xAAAA0000.
REQ-035 DEPTH=256: write 0x55 at address 0x400 -> read at 0x000 returns 0x55 (wrap).
REQ-036 With MEM_ALIGN_CHECK_EN, write to 0x41 -> MemWriteDone=1 and memErr=1; array is unchanged.
